// File: rtl/decode_issue_stage_if.sv
// Bundle between fetch, the register file, writeback and execute as seen by
// the decode/issue stage. The stage itself takes the slave view; whoever
// drives fetch/writeback and consumes execute takes the master view.
interface decode_issue_stage_if #(
    parameter int IW = 32,
    parameter int DW = 16
);
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic          in_ready;

    logic [5:0]    rf_rd_addr_1;
    logic [5:0]    rf_rd_addr_2;
    logic [DW-1:0] rf_rd_data_1;
    logic [DW-1:0] rf_rd_data_2;

    logic          wb_en;
    logic [5:0]    wb_dest;
    logic [DW-1:0] wb_data;

    logic          flush;

    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_opcode;
    logic [4:0]    out_rd;
    logic          out_we;
    logic [DW-1:0] out_op_a;
    logic [DW-1:0] out_op_b;
    logic [DW-1:0] out_imm;

    modport slave (
        input  in_valid, in_instr,
        output in_ready,
        output rf_rd_addr_1, rf_rd_addr_2,
        input  rf_rd_data_1, rf_rd_data_2,
        input  wb_en, wb_dest, wb_data,
        input  flush,
        output out_valid, out_opcode, out_rd, out_we, out_op_a, out_op_b, out_imm,
        input  out_ready
    );

    modport master (
        output in_valid, in_instr,
        input  in_ready,
        input  rf_rd_addr_1, rf_rd_addr_2,
        output rf_rd_data_1, rf_rd_data_2,
        output wb_en, wb_dest, wb_data,
        output flush,
        input  out_valid, out_opcode, out_rd, out_we, out_op_a, out_op_b, out_imm,
        output out_ready
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: splits the instruction word, reads the register file,
// forwards same-cycle writeback data, tracks pending writes in a busy
// scoreboard and holds fetch on RAW/WAW hazards.
module decode_issue_stage #(
    parameter int IW   = 32,
    parameter int DW   = 16,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_issue_stage_if.slave  bus
);
    // Instruction fields; imm overlaps rs2 by design of the encoding
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
    logic [DW-1:0] imm_sx;

    assign opcode = bus.in_instr[IW-1 -: 6];
    assign rd     = bus.in_instr[25:21];
    assign rs1    = bus.in_instr[20:16];
    assign rs2    = bus.in_instr[15:11];
    assign imm    = bus.in_instr[15:0];
    assign imm_sx = DW'($signed(imm));

    // Read addresses follow in_instr even when in_valid is low
    assign bus.rf_rd_addr_1 = {1'b0, rs1};
    assign bus.rf_rd_addr_2 = {1'b0, rs2};

    // Instruction class: NOP, store/branch (no write), immediate (no rs2)
    logic is_nop;
    logic is_imm;
    logic is_sb;
    logic use_1;
    logic use_2;
    logic we;

    assign is_nop = (opcode == 6'h00);
    assign is_sb  = (opcode[5:4] == 2'b11);
    assign is_imm = (opcode[5:4] == 2'b10);
    assign use_1  = !is_nop;
    assign use_2  = !is_nop && !is_imm;
    assign we     = !is_nop && !is_sb && (rd != 5'd0);

    // Writeback this cycle targets one of our registers
    logic wb_hit_1;
    logic wb_hit_2;
    logic wb_hit_rd;

    assign wb_hit_1  = bus.wb_en && (bus.wb_dest == {1'b0, rs1});
    assign wb_hit_2  = bus.wb_en && (bus.wb_dest == {1'b0, rs2});
    assign wb_hit_rd = bus.wb_en && (bus.wb_dest == {1'b0, rd});

    // Operand select: r0 reads as zero, otherwise writeback beats the RF
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;

    always_comb begin
        op_a = bus.rf_rd_data_1;
        if (rs1 == 5'd0)
            op_a = '0;
        else if (wb_hit_1)
            op_a = bus.wb_data;

        op_b = bus.rf_rd_data_2;
        if (is_imm)
            op_b = imm_sx;
        else if (rs2 == 5'd0)
            op_b = '0;
        else if (wb_hit_2)
            op_b = bus.wb_data;
    end

    // Hazard detection against the busy scoreboard; a register being
    // written back this cycle is no longer considered pending
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            hazard;
    logic            advance;
    logic            load;

    always_comb begin
        hazard = 1'b0;
        if (use_1 && (rs1 != 5'd0) && busy[rs1] && !wb_hit_1)
            hazard = 1'b1;
        if (use_2 && (rs2 != 5'd0) && busy[rs2] && !wb_hit_2)
            hazard = 1'b1;
        if (we && busy[rd] && !wb_hit_rd)
            hazard = 1'b1;
    end

    logic          out_valid_q;
    logic [5:0]    out_opcode_q;
    logic [4:0]    out_rd_q;
    logic          out_we_q;
    logic [DW-1:0] out_op_a_q;
    logic [DW-1:0] out_op_b_q;
    logic [DW-1:0] out_imm_q;

    assign advance      = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign load         = bus.in_valid && advance;
    assign bus.in_ready = advance || bus.flush;

    // Decode/execute pipeline register; flush discards its contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_opcode_q <= '0;
            out_rd_q     <= '0;
            out_we_q     <= 1'b0;
            out_op_a_q   <= '0;
            out_op_b_q   <= '0;
            out_imm_q    <= '0;
        end else if (bus.flush) begin
            out_valid_q  <= 1'b0;
        end else if (load) begin
            out_valid_q  <= 1'b1;
            out_opcode_q <= opcode;
            out_rd_q     <= rd;
            out_we_q     <= we;
            out_op_a_q   <= op_a;
            out_op_b_q   <= op_b;
            out_imm_q    <= imm_sx;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_opcode = out_opcode_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_we     = out_we_q;
    assign bus.out_op_a   = out_op_a_q;
    assign bus.out_op_b   = out_op_b_q;
    assign bus.out_imm    = out_imm_q;

    // Scoreboard update: writeback and flushed writes clear, issue sets
    // last so a same-cycle set wins over a clear
    always_comb begin
        busy_nxt = busy;
        if (bus.wb_en && !bus.wb_dest[5])
            busy_nxt[bus.wb_dest[4:0]] = 1'b0;
        if (bus.flush && out_valid_q && out_we_q)
            busy_nxt[out_rd_q] = 1'b0;
        if (load && we)
            busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end
endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: a vector table of independent issues with
// expected results queued at issue time and checked as execute accepts them,
// followed by hand sequences for stall, backpressure, flush and reset.
module tb_decode_issue_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_issue_stage_if #(.IW(32), .DW(16)) bus ();

    decode_issue_stage #(.IW(32), .DW(16), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        wb_en;
        logic [5:0]  wb_dest;
        logic [15:0] wb_data;
        exp_t        res;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    vec_t tbl[8];

    // Register file model, re-initialised while rst is held at a clock edge
    logic [15:0] rf [32];

    function automatic logic [15:0] rf_init(input int i);
        if (i == 0) return 16'hDEAD;
        if (i == 1) return 16'h0005;
        if (i == 2) return 16'h0007;
        return 16'h0100 | 16'(i);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
        end else if (bus.wb_en && !bus.wb_dest[5]) begin
            rf[bus.wb_dest[4:0]] <= bus.wb_data;
        end
    end

    assign bus.rf_rd_data_1 = rf[bus.rf_rd_addr_1[4:0]];
    assign bus.rf_rd_data_2 = rf[bus.rf_rd_addr_2[4:0]];

    function automatic logic [31:0] rfm(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'h000};
    endfunction

    function automatic logic [31:0] ifm(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic exp_t ex(input logic [5:0] op, input logic [4:0] rd, input logic we,
                                input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm);
        exp_t e;
        e.op = op; e.rd = rd; e.we = we; e.a = a; e.b = b; e.imm = imm;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Drive one instruction from a negedge, wait (bounded) for acceptance
    task automatic issue(input logic [31:0] instr, input logic wen, input logic [5:0] wd,
                         input logic [15:0] wdat, input exp_t e, input logic push);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.wb_en    = wen;
        bus.wb_dest  = wd;
        bus.wb_data  = wdat;
        #1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("issue_ready", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready === 1'b1 && push) q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    // Scoreboard consumer: compare whenever execute accepts an output
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && bus.flush === 1'b0) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_opcode", 64'(bus.out_opcode), 64'(e.op));
                    chk("out_rd",     64'(bus.out_rd),     64'(e.rd));
                    chk("out_we",     64'(bus.out_we),     64'(e.we));
                    chk("out_op_a",   64'(bus.out_op_a),   64'(e.a));
                    chk("out_op_b",   64'(bus.out_op_b),   64'(e.b));
                    chk("out_imm",    64'(bus.out_imm),    64'(e.imm));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{rfm(6'h01, 5'd3, 5'd1, 5'd2), 1'b0, 6'd0,  16'h0000, ex(6'h01, 5'd3, 1'b1, 16'h0005, 16'h0007, 16'h1000)};
        tbl[1] = '{rfm(6'h02, 5'd0, 5'd5, 5'd6), 1'b0, 6'd0,  16'h0000, ex(6'h02, 5'd0, 1'b0, 16'h0105, 16'h0106, 16'h3000)};
        tbl[2] = '{ifm(6'h21, 5'd5, 5'd0, 16'hFFF0), 1'b0, 6'd0, 16'h0000, ex(6'h21, 5'd5, 1'b1, 16'h0000, 16'hFFF0, 16'hFFF0)};
        tbl[3] = '{rfm(6'h30, 5'd3, 5'd6, 5'd7), 1'b1, 6'd3,  16'h000C, ex(6'h30, 5'd3, 1'b0, 16'h0106, 16'h0107, 16'h3800)};
        tbl[4] = '{rfm(6'h05, 5'd0, 5'd3, 5'd4), 1'b1, 6'd4,  16'h0044, ex(6'h05, 5'd0, 1'b0, 16'h000C, 16'h0044, 16'h2000)};
        tbl[5] = '{rfm(6'h00, 5'd5, 5'd5, 5'd5), 1'b1, 6'h25, 16'hBEEF, ex(6'h00, 5'd5, 1'b0, 16'h0105, 16'h0105, 16'h2800)};
        tbl[6] = '{ifm(6'h21, 5'd6, 5'd5, 16'h8001), 1'b1, 6'd5, 16'h0055, ex(6'h21, 5'd6, 1'b1, 16'h0055, 16'h8001, 16'h8001)};
        tbl[7] = '{rfm(6'h01, 5'd6, 5'd1, 5'd2), 1'b1, 6'd6,  16'h0066, ex(6'h01, 5'd6, 1'b1, 16'h0005, 16'h0007, 16'h1000)};

        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.wb_en     = 1'b0;
        bus.wb_dest   = '0;
        bus.wb_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_rd",    64'(bus.out_rd),    64'd0);
        chk("rst_out_op_a",  64'(bus.out_op_a),  64'd0);
        chk("rst_out_imm",   64'(bus.out_imm),   64'd0);
        chk("rst_busy",      64'(dut.busy),      64'd0);
        rst = 1'b0;

        // Table of issues, each with its own same-cycle writeback
        for (int i = 0; i < 8; i++)
            issue(tbl[i].instr, tbl[i].wb_en, tbl[i].wb_dest, tbl[i].wb_data, tbl[i].res, 1'b1);
        drain();
        chk("busy_after_table", 64'(dut.busy), 64'h40);

        // RAW stall on r3, released by writeback with forwarding
        issue(rfm(6'h01, 5'd3, 5'd1, 5'd2), 1'b0, 6'd0, 16'h0, ex(6'h01, 5'd3, 1'b1, 16'h0005, 16'h0007, 16'h1000), 1'b1);
        chk("busy3_set", 64'(dut.busy[3]), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = rfm(6'h01, 5'd8, 5'd3, 5'd0);
        #1 chk("raw_stall_0", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        #1 chk("raw_stall_1", 64'(bus.in_ready), 64'd0);
        bus.wb_en   = 1'b1;
        bus.wb_dest = 6'd3;
        bus.wb_data = 16'h000C;
        #1 chk("raw_release", 64'(bus.in_ready), 64'd1);
        q.push_back(ex(6'h01, 5'd8, 1'b1, 16'h000C, 16'h0000, 16'h0000));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
        drain();

        // Backpressure: outputs hold, next instruction waits
        bus.out_ready = 1'b0;
        issue(rfm(6'h01, 5'd9, 5'd1, 5'd2), 1'b0, 6'd0, 16'h0, ex(6'h01, 5'd9, 1'b1, 16'h0005, 16'h0007, 16'h1000), 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = rfm(6'h01, 5'd10, 5'd1, 5'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_rd",    64'(bus.out_rd),    64'd9);
            chk("bp_out_op_b",  64'(bus.out_op_b),  64'h0007);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release", 64'(bus.in_ready), 64'd1);
        q.push_back(ex(6'h01, 5'd10, 1'b1, 16'h0005, 16'h0005, 16'h0800));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain();

        // Flush with a pending write to r7 in the output register
        bus.out_ready = 1'b0;
        issue(rfm(6'h01, 5'd7, 5'd1, 5'd2), 1'b0, 6'd0, 16'h0, '0, 1'b0);
        @(negedge clk);
        chk("fl_pre_valid", 64'(bus.out_valid), 64'd1);
        chk("fl_pre_busy7", 64'(dut.busy[7]),   64'd1);
        bus.in_valid = 1'b1;
        bus.in_instr = rfm(6'h01, 5'd11, 5'd1, 5'd2);
        bus.flush    = 1'b1;
        #1 chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_busy7",     64'(dut.busy[7]),   64'd0);
        chk("fl_busy11",    64'(dut.busy[11]),  64'd0);
        @(negedge clk);
        chk("fl_dropped", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a stall with busy bits set
        issue(rfm(6'h01, 5'd12, 5'd1, 5'd2), 1'b0, 6'd0, 16'h0, '0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = rfm(6'h01, 5'd13, 5'd6, 5'd0);
        #1 chk("mid_stall", 64'(bus.in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_rd",    64'(bus.out_rd),    64'd0);
        chk("mid_rst_we",    64'(bus.out_we),    64'd0);
        chk("mid_rst_op_a",  64'(bus.out_op_a),  64'd0);
        chk("mid_rst_busy",  64'(dut.busy),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1 chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
        q.push_back(ex(6'h01, 5'd13, 1'b1, 16'h0106, 16'h0000, 16'h0000));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("post_rst_busy", 64'(dut.busy), 64'(32'h1 << 13));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
